// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// store_pkg : shared state and store-size encodings for the store path.
// Rev 1.0
// ============================================================================
package store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Shared with the load-size path; keep the two in step.
  localparam logic [1:0] SZ_INV  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  function automatic logic is_subword(input logic [1:0] sz);
    return (sz == SZ_HALF) || (sz == SZ_BYTE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
// store_merge : combinational merge of store data into the old memory word.
// Rev 1.0
// ============================================================================
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [31:0] i_reg_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_wdata = '0;
    case (i_size)
      SZ_WORD: o_wdata = i_reg_data;
      SZ_HALF: o_wdata = {i_rdata[31:16], i_reg_data[15:0]};
      SZ_BYTE: o_wdata = {i_rdata[31:8], i_reg_data[7:0]};
      default: o_wdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_size_rmw.sv
`default_nettype none
// ============================================================================
// store_size_rmw : store-width sequencer; word stores write directly,
// halfword/byte stores read-modify-write the addressed word.   Rev 1.0
// ============================================================================
module store_size_rmw
  import store_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  SSCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] c_cnt_last = 3'(READ_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_reg;
  logic [31:0] r_rdata;
  logic        r_mem_wr;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] w_merged;

  store_merge u_merge (
    .i_size     (r_size),
    .i_reg_data (r_reg),
    .i_rdata    (r_rdata),
    .o_wdata    (w_merged)
  );

  // Output flags are registered together with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_reg    <= '0;
      r_rdata  <= '0;
      r_mem_wr <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_size <= SSCtrl;
            r_addr <= addr;
            r_reg  <= reg_data;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (SSCtrl == SZ_WORD) begin
              r_state  <= WRITE;
              r_mem_wr <= 1'b1;
            end else if (is_subword(SSCtrl)) begin
              r_state <= READ;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_cnt == c_cnt_last) begin
            r_rdata  <= mem_rdata;
            r_state  <= WRITE;
            r_mem_wr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = (r_state != IDLE) ? r_addr : '0;
  assign mem_wdata = r_mem_wr ? w_merged : '0;
  assign mem_wr    = r_mem_wr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_size_rmw.sv
`default_nettype none
// ============================================================================
// tb_store_size_rmw : bench for store_size_rmw at READ_LAT 1 and 3.
// Rev 1.0
// ============================================================================
module tb_store_size_rmw;
  import store_pkg::*;

  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start     [2];
  logic [1:0]  ssctrl    [2];
  logic [31:0] addr      [2];
  logic [31:0] reg_data  [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_wr    [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];

  store_size_rmw #(.READ_LAT(L0)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start[0]), .SSCtrl(ssctrl[0]),
    .addr(addr[0]), .reg_data(reg_data[0]), .mem_rdata(mem_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  store_size_rmw #(.READ_LAT(L1)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start[1]), .SSCtrl(ssctrl[1]),
    .addr(addr[1]), .reg_data(reg_data[1]), .mem_rdata(mem_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Read-only memory contents; address 0 holds a poison value so an early capture shows up.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0)  return 32'hBAD0BAD0;
    if (a == 32'h44) return 32'h11223344;
    return {8'hA5, a[23:0]};
  endfunction

  // Memory port: combinational for latency 1, a two-stage pipe for latency 3.
  logic [31:0] rpipe [2][2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rpipe[d][0] <= memval(mem_addr[d]);
      rpipe[d][1] <= rpipe[d][0];
    end
  end
  always_comb begin
    mem_rdata[0] = memval(mem_addr[0]);
    mem_rdata[1] = rpipe[1][L1-2];
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  // Cycle (counted from 1 after the accepted start) in which done is expected.
  function automatic int end_of(input logic [1:0] sz, input int lat);
    if (sz == SZ_WORD) return 2;
    if (sz == SZ_INV)  return 1;
    return lat + 2;
  endfunction

  function automatic int wr_of(input logic [1:0] sz, input int lat);
    if (sz == SZ_WORD) return 1;
    if (sz == SZ_INV)  return -1;
    return lat + 1;
  endfunction

  function automatic logic [31:0] exp_data(input logic [1:0] sz, input logic [31:0] r, input logic [31:0] m);
    logic [31:0] mask;
    mask = (sz == SZ_HALF) ? 32'h0000FFFF : (sz == SZ_BYTE) ? 32'h000000FF : 32'hFFFFFFFF;
    return (m & ~mask) | (r & mask);
  endfunction

  // Timeline model: m_t is the cycle index within the current operation, 0 when idle.
  int          m_t    [2];
  logic [1:0]  m_sz   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_reg  [2];

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        m_t[d] <= 0;
      end else if (m_t[d] == 0) begin
        if (start[d]) begin
          m_t[d]    <= 1;
          m_sz[d]   <= ssctrl[d];
          m_addr[d] <= addr[d];
          m_reg[d]  <= reg_data[d];
        end
      end else if (m_t[d] >= end_of(m_sz[d], lat_of(d))) begin
        m_t[d] <= 0;
      end else begin
        m_t[d] <= m_t[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int          t    = m_t[d];
      automatic logic        e_bz = (t != 0);
      automatic logic        e_wr = (t != 0) && (t == wr_of(m_sz[d], lat_of(d)));
      automatic logic        e_dn = (t != 0) && (t == end_of(m_sz[d], lat_of(d)));
      automatic logic        e_er = e_dn && (m_sz[d] == SZ_INV);
      automatic logic [31:0] e_ad = e_bz ? m_addr[d] : 32'h0;
      automatic logic [31:0] e_wd = e_wr ? exp_data(m_sz[d], m_reg[d], memval(m_addr[d])) : 32'h0;
      chk("model_busy", d, {31'b0, busy[d]}, {31'b0, e_bz});
      chk("model_mem_wr", d, {31'b0, mem_wr[d]}, {31'b0, e_wr});
      chk("model_done", d, {31'b0, done[d]}, {31'b0, e_dn});
      chk("model_err", d, {31'b0, err[d]}, {31'b0, e_er});
      chk("model_mem_addr", d, mem_addr[d], e_ad);
      chk("model_mem_wdata", d, mem_wdata[d], e_wd);
    end
  end

  int wr_cnt   [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) wr_cnt[d] <= wr_cnt[d] + 1;
      if (done[d])   done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  // Returns #1 after the edge that samples start, i.e. in cycle 1.
  task automatic issue(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] r);
    @(negedge clk);
    start[d] = 1'b1; ssctrl[d] = sz; addr[d] = a; reg_data[d] = r;
    @(posedge clk); #1;
    start[d] = 1'b0; ssctrl[d] = ~sz; addr[d] = ~a; reg_data[d] = ~r;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_zero(input string name, input int d);
    chk({name, "_busy"}, d, {31'b0, busy[d]}, 32'h0);
    chk({name, "_wr"}, d, {31'b0, mem_wr[d]}, 32'h0);
    chk({name, "_done"}, d, {31'b0, done[d]}, 32'h0);
    chk({name, "_err"}, d, {31'b0, err[d]}, 32'h0);
    chk({name, "_addr"}, d, mem_addr[d], 32'h0);
    chk({name, "_wdata"}, d, mem_wdata[d], 32'h0);
  endtask

  initial begin
    int w, dn;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; ssctrl[d] = 2'b00; addr[d] = '0; reg_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset", 0);
    chk_idle_zero("reset", 1);
    @(negedge clk) reset = 1'b1;

    // Word store, latency 1.
    issue(0, SZ_WORD, 32'h40, 32'hDEADBEEF);
    chk("word_wr", 0, {31'b0, mem_wr[0]}, 32'h1);
    chk("word_addr", 0, mem_addr[0], 32'h40);
    chk("word_wdata", 0, mem_wdata[0], 32'hDEADBEEF);
    next_cycle;
    chk("word_done", 0, {31'b0, done[0]}, 32'h1);
    next_cycle;
    chk("word_idle", 0, {31'b0, busy[0]}, 32'h0);

    // Halfword store, latency 1.
    w = wr_cnt[0];
    issue(0, SZ_HALF, 32'h44, 32'hAAAABBBB);
    chk("half_read_wr", 0, {31'b0, mem_wr[0]}, 32'h0);
    next_cycle;
    chk("half_wdata", 0, mem_wdata[0], 32'h1122BBBB);
    next_cycle;
    chk("half_done", 0, {31'b0, done[0]}, 32'h1);
    next_cycle;
    chk("half_writes", 0, 32'(wr_cnt[0] - w), 32'd1);

    // Byte store, latency 3.
    issue(1, SZ_BYTE, 32'h44, 32'h000000CC);
    for (int k = 1; k <= 3; k++) begin
      chk("byte_read_wr", 1, {31'b0, mem_wr[1]}, 32'h0);
      chk("byte_read_addr", 1, mem_addr[1], 32'h44);
      next_cycle;
    end
    chk("byte_wdata", 1, mem_wdata[1], 32'h112233CC);
    next_cycle;
    chk("byte_done", 1, {31'b0, done[1]}, 32'h1);
    next_cycle;

    // Invalid size.
    w = wr_cnt[0];
    issue(0, SZ_INV, 32'h48, 32'h12345678);
    chk("inv_done", 0, {31'b0, done[0]}, 32'h1);
    chk("inv_err", 0, {31'b0, err[0]}, 32'h1);
    next_cycle;
    next_cycle;
    chk("inv_no_write", 0, 32'(wr_cnt[0] - w), 32'd0);

    // Disturbance during READ: extra start and operand changes are ignored.
    w = wr_cnt[1];
    issue(1, SZ_BYTE, 32'h44, 32'h0000005A);
    next_cycle;
    start[1] = 1'b1; ssctrl[1] = SZ_WORD; addr[1] = 32'h80; reg_data[1] = 32'hFFFFFFFF;
    next_cycle;
    start[1] = 1'b0;
    next_cycle;
    chk("disturb_wdata", 1, mem_wdata[1], 32'h1122335A);
    chk("disturb_addr", 1, mem_addr[1], 32'h44);
    repeat (4) next_cycle;
    chk("disturb_writes", 1, 32'(wr_cnt[1] - w), 32'd1);

    // Reset during READ aborts with no later write.
    w = wr_cnt[1];
    issue(1, SZ_BYTE, 32'h44, 32'h00000077);
    next_cycle;
    #2 reset = 1'b0;
    #1;
    chk_idle_zero("abort", 1);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) next_cycle;
    chk("abort_writes", 1, 32'(wr_cnt[1] - w), 32'd0);

    // Back-to-back: start in DONE is dropped, start in the following IDLE is taken.
    w  = wr_cnt[0];
    dn = done_cnt[0];
    issue(0, SZ_WORD, 32'h40, 32'h01020304);
    next_cycle;
    chk("b2b_done1", 0, {31'b0, done[0]}, 32'h1);
    start[0] = 1'b1; ssctrl[0] = SZ_WORD; addr[0] = 32'h48; reg_data[0] = 32'h55;
    next_cycle;
    chk("b2b_idle", 0, {31'b0, busy[0]}, 32'h0);
    ssctrl[0] = SZ_HALF; addr[0] = 32'h44; reg_data[0] = 32'h0000CAFE;
    next_cycle;
    start[0] = 1'b0;
    chk("b2b_busy", 0, {31'b0, busy[0]}, 32'h1);
    next_cycle;
    chk("b2b_wdata", 0, mem_wdata[0], 32'h1122CAFE);
    next_cycle;
    next_cycle;
    chk("b2b_writes", 0, 32'(wr_cnt[0] - w), 32'd2);
    chk("b2b_dones", 0, 32'(done_cnt[0] - dn), 32'd2);

    repeat (3) next_cycle;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/store_size_rmw.md
# store_size_rmw

Store-width sequencer for the multicycle datapath, the write-side counterpart of the load-size extractor. It takes a store request (word, halfword or byte) with the B-register value and a word address. Word stores go straight to memory. Halfword and byte stores run a read-modify-write: read the memory word, replace its low 16 or 8 bits, write the merged word back. It sits between the control unit (start/done handshake) and the memory port, replacing the control unit's direct drive of memory write data.

## Interface

- `READ_LAT`, default 1: memory read latency in cycles, legal range 1..4. `mem_rdata` is valid `READ_LAT` cycles after the address is presented with `mem_wr`=0.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request pulse, sampled only in IDLE.
- `SSCtrl` input 2: store size. 01 = word, 10 = halfword, 11 = byte, 00 = invalid.
- `addr` input 32: word address, captured at start.
- `reg_data` input 32: store source (B register), captured at start.
- `mem_rdata` input 32: memory read data.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_wr` output 1: memory write enable, one cycle per store.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle pulse coincident with `done` for an invalid SSCtrl.

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE, `start`=1: capture `SSCtrl`, `addr` and `reg_data` into registers, then:
  - SSCtrl 01 goes to WRITE.
  - SSCtrl 10 or 11 goes to READ.
  - SSCtrl 00 goes to DONE with an error flag set.
- READ:
  - `mem_addr` = captured address, `mem_wr`=0.
  - A wait counter runs `READ_LAT` cycles. In the last READ cycle, `mem_rdata` is captured into a merge register, then go to WRITE.
- WRITE:
  - `mem_wr`=1 for exactly one cycle, `mem_addr` = captured address, then go to DONE.
  - Write data by size:
    - word: `reg_data[31:0]`
    - halfword: {`rdata_q[31:16]`, `reg_data[15:0]`}
    - byte: {`rdata_q[31:8]`, `reg_data[7:0]`}
- DONE: `done`=1; `err`=1 only for invalid size. Return to IDLE.
- Once out of IDLE, `start` is ignored until the block is back in IDLE. A `start` in the DONE cycle is dropped.
- Captured operands are held for the whole operation. Changes on `addr`, `reg_data` or `SSCtrl` mid-operation have no effect.
- Output values outside their active states:
  - `mem_wdata` = 0 except in WRITE.
  - `mem_addr` holds the captured address in all non-IDLE states and is 0 in IDLE.

## Timing

- Reset (`reset`=0) drives these immediately, asynchronously: state IDLE, counter 0, all captured registers 0, `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0, `busy`=0, `done`=0, `err`=0.
- Reset in the middle of an operation aborts it. No partial write occurs after reset is asserted.
- Latency, with `start` seen at edge 0:
  - Word: WRITE in cycle 1, `done` in cycle 2.
  - Halfword/byte: READ in cycles 1..`READ_LAT`, WRITE in cycle `READ_LAT`+1, `done` in cycle `READ_LAT`+2.
  - Invalid: `done`+`err` in cycle 1, no memory access.
- `busy` rises in the cycle after `start` and falls in the cycle after DONE.
- All outputs are decoded from registered state only, with no combinational path from inputs.

## Structure

- Shared package `store_pkg`:
  - State enum: IDLE/READ/WRITE/DONE.
  - Size constants: SZ_WORD=2'b01, SZ_HALF=2'b10, SZ_BYTE=2'b11, SZ_INV=2'b00. The same encoding is used by the load-size path.
- One natural sub-module, `store_merge`: purely combinational. Inputs: size, captured register data, captured read data. Output: merged write word. Kept separate so it can be unit-tested exhaustively.
- FSM, wait counter and capture registers stay in the top module.

## Test plan

- Word store, READ_LAT=1: SSCtrl=01, addr=0x40, reg_data=0xDEADBEEF.
  - Expect WRITE in cycle 1 with `mem_wr`=1, `mem_addr`=0x40, `mem_wdata`=0xDEADBEEF, and no read cycle.
  - Expect `done` in cycle 2.
- Halfword store: memory word 0x11223344, reg_data=0xAAAABBBB, SSCtrl=10.
  - Expect `mem_wdata`=0x1122BBBB in the WRITE cycle and `done` at cycle 3.
- Byte store with READ_LAT=3: memory word 0x11223344, reg_data=0x000000CC, SSCtrl=11.
  - Expect READ in cycles 1..3, `mem_wdata`=0x112233CC in cycle 4, `done` in cycle 5.
- Invalid size, SSCtrl=00: expect `done`=`err`=1 in cycle 1 and `mem_wr` never asserted.
- Mid-operation disturbance on a byte store:
  - A `start` pulse and `reg_data` change during READ are ignored. Exactly one write, with the original merged data.
  - Separately, `reset`=0 asserted during READ gives all outputs 0 at once, state IDLE, and no `mem_wr` pulse afterwards.
- Back-to-back: a second `start` in the IDLE cycle right after DONE is accepted. Two writes occur and `done` pulses twice.
